scroll_display_mux: RTL and testbench
=====================================

Name: scroll_display_mux

Overview:
- Upstream feeder for the character-to-7-segment decoder on the 4-digit board display.
- Holds a small text buffer, loaded one ASCII byte at a time; the source is a UART receiver or the keypad path.
- Time-multiplexes the 4 digits: presents one ASCII character per refresh slot on `char`, together with the matching active-low anode enable on `an`.
- When the text is longer than 4 characters, scrolls it right-to-left circularly, with one blank gap between passes.

Parameters:
- DEPTH, 16: text buffer capacity in characters; power of 2, minimum 8.
- REFRESH_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz).
- SCROLL_DIV, 50000000: clk cycles per scroll step (0.5 s at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  append wr_char to buffer this cycle.
- wr_char  in  8  ASCII character to append.
- clear  in  1  empty the buffer (synchronous).
- scroll_en  in  1  1 = scrolling allowed; 0 = freeze the current window.
- char  out  8  ASCII code for the currently enabled digit; feeds the 7-segment decoder.
- an  out  4  digit anodes, active-low, one-hot-low; an[3] is the leftmost digit.
- len  out  $clog2(DEPTH)+1  number of valid characters in the buffer.
- full  out  1  high when len == DEPTH.

Behaviour:
- Reset (async, active-high): len=0, offset=0, refresh and scroll counters=0, digit_sel=0, an=4'b0111, char=8'h20. The buffer RAM is not cleared.
- Buffer write: when wr_en=1 and full=0, buf[len] <= wr_char and len <= len+1. A write while full is dropped silently, and len is unchanged.
- clear: len <= 0, offset <= 0. If clear and wr_en are asserted in the same cycle, clear wins and the write is dropped.
- Refresh counter: counts 0..REFRESH_DIV-1. On its terminal count, digit_sel advances 0→1→2→3→0.
- Anode mapping: digit_sel d maps to an = ~(4'b1000 >> d), i.e. d=0 is the leftmost digit.
- `an` and `char` are both registered and update in the same clk edge at the refresh terminal count. They never disagree for a cycle.
- Character selection for slot d (computed from the next digit_sel):
  - len == 0: char = 8'h20 (space; the decoder blanks it by default).
  - len <= 4: char = buf[d] if d < len, else 8'h20. Left-aligned, no scroll; offset is held at 0.
  - len > 4: virtual length L = len+1 (one trailing gap). Index i = (offset + d) mod L. char = 8'h20 if i == len, else buf[i].
- Scroll counter:
  - Counts 0..SCROLL_DIV-1 only while scroll_en=1 and len > 4. Otherwise it is held at 0.
  - On its terminal count, offset <= (offset == len) ? 0 : offset+1, which wraps over L positions.
- Writes while scrolling: offset is preserved; the new L takes effect immediately. If a clear races with a scroll tick in the same cycle, clear wins (offset=0).
- scroll_en deasserted: offset freezes and the counter resets to 0. Re-enabling restarts a full SCROLL_DIV interval.
- Modulo arithmetic is done with a compare-and-subtract, because offset+d < 2L. No divider is inferred.
- Reset mid-operation returns all state to the reset values above on the next evaluation, independent of clk.

Test Plan (REFRESH_DIV=4, SCROLL_DIV=32, DEPTH=8):
1. Reset, no writes → an cycles 0111,1011,1101,1110 every 4 clks; char=8'h20 in every slot.
2. Write "AB" → slots show 8'h41, 8'h42, 8'h20, 8'h20. scroll_en=1 for 200 clks → offset stays 0, window unchanged.
3. Write "HELLO" (len=5) with scroll_en=1:
   - Initial window H,E,L,L.
   - After 32 clks: E,L,L,O.
   - Then L,L,O,space.
   - Then L,O,space,H.
   - Offset returns to 0 after 6 ticks (192 clks).
4. Write 8 chars, then a 9th → full=1, len=8, 9th char never displayed. The same cycle with clear=1 and wr_en=1 → len=0, all slots 8'h20.
5. Mid-scroll (offset=3), drop scroll_en for 100 clks → window frozen. Re-enable → next step exactly 32 clks later.
6. Assert reset between clk edges mid-scroll → an=0111, char=8'h20, len=0 immediately. Release → refresh restarts from digit 0.

Source files
------------

// File: rtl/scroll_display_mux.sv
// Scrolling text feeder for a 4-digit multiplexed display: buffers ASCII text and
// presents one character per refresh slot with its active-low anode enable.
module scroll_display_mux #(
  parameter int DEPTH       = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int SCROLL_DIV  = 50000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_char,
  input  logic                     clear,
  input  logic                     scroll_en,
  output logic [7:0]               char,
  output logic [3:0]               an,
  output logic [$clog2(DEPTH):0]   len,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int SW = $clog2(SCROLL_DIV + 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCROLL_LAST  = SW'(SCROLL_DIV - 1);
  localparam logic [7:0]    SPACE        = 8'h20;

  logic [7:0]    mem_q [DEPTH];
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] offset_q, offset_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [SW-1:0] scroll_q, scroll_d;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    char_q, char_d;

  logic          full_s, wr_ok_s, refresh_tick_s, scroll_active_s, scroll_tick_s;
  logic [LW:0]   vlen_s, sum_s;
  logic [LW-1:0] idx_s;
  logic [7:0]    sel_char_s;

  assign full_s  = (len_q == LW'(DEPTH));
  assign wr_ok_s = wr_en & ~full_s & ~clear;

  // Text buffer RAM; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[len_q[AW-1:0]] <= wr_char;
    end
  end

  // Next-state logic for counters, buffer length, scroll offset and display outputs.
  always_comb begin
    refresh_d       = refresh_q;
    digit_d         = digit_q;
    scroll_d        = scroll_q;
    len_d           = len_q;
    offset_d        = offset_q;
    an_d            = an_q;
    char_d          = char_q;
    sel_char_s      = SPACE;
    vlen_s          = (LW + 1)'(len_q) + (LW + 1)'(1);
    sum_s           = '0;
    idx_s           = '0;

    refresh_tick_s  = (refresh_q == REFRESH_LAST);
    scroll_active_s = scroll_en && (len_q > LW'(4));
    scroll_tick_s   = scroll_active_s && (scroll_q == SCROLL_LAST);

    if (refresh_tick_s) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
    end else begin
      refresh_d = refresh_q + RW'(1);
    end

    if (clear || !scroll_active_s || scroll_tick_s) begin
      scroll_d = '0;
    end else begin
      scroll_d = scroll_q + SW'(1);
    end

    if (clear) begin
      len_d    = '0;
      offset_d = '0;
    end else begin
      if (wr_ok_s) begin
        len_d = len_q + LW'(1);
      end else begin
        len_d = len_q;
      end
      if (scroll_tick_s) begin
        offset_d = (offset_q == len_q) ? LW'(0) : offset_q + LW'(1);
      end else begin
        offset_d = offset_q;
      end
    end

    // offset + digit < 2L, so a single conditional subtract gives the modulo.
    sum_s = (LW + 1)'(offset_q) + (LW + 1)'(digit_d);
    idx_s = (sum_s >= vlen_s) ? LW'(sum_s - vlen_s) : LW'(sum_s);

    if (len_q == LW'(0)) begin
      sel_char_s = SPACE;
    end else if (len_q <= LW'(4)) begin
      sel_char_s = (LW'(digit_d) < len_q) ? mem_q[AW'(digit_d)] : SPACE;
    end else begin
      sel_char_s = (idx_s == len_q) ? SPACE : mem_q[idx_s[AW-1:0]];
    end

    if (refresh_tick_s) begin
      an_d   = ~(4'b1000 >> digit_d);
      char_d = sel_char_s;
    end else begin
      an_d   = an_q;
      char_d = char_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      digit_q   <= 2'd0;
      scroll_q  <= '0;
      len_q     <= '0;
      offset_q  <= '0;
      an_q      <= 4'b0111;
      char_q    <= SPACE;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      scroll_q  <= scroll_d;
      len_q     <= len_d;
      offset_q  <= offset_d;
      an_q      <= an_d;
      char_q    <= char_d;
    end
  end

  assign char = char_q;
  assign an   = an_q;
  assign len  = len_q;
  assign full = full_s;

endmodule

// File: tb/tb_scroll_display_mux.sv
// Directed self-checking bench for scroll_display_mux (DEPTH=8, REFRESH_DIV=4, SCROLL_DIV=32).
module tb_scroll_display_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_char;
  logic       clear;
  logic       scroll_en;
  logic [7:0] char;
  logic [3:0] an;
  logic [3:0] len;
  logic       full;

  int checks   = 0;
  int failures = 0;

  scroll_display_mux #(.DEPTH(8), .REFRESH_DIV(4), .SCROLL_DIV(32)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_char(wr_char), .clear(clear),
    .scroll_en(scroll_en), .char(char), .an(an), .len(len), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Returns at the first negedge of a digit-0 slot (bounded wait).
  task automatic sync0(input string tag);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      prev = an;
      @(negedge clk);
      if (an == 4'b0111 && prev != 4'b0111) found = 1'b1;
    end
    check_eq({tag, "_sync"}, {31'd0, found}, 32'd1);
  endtask

  task automatic get_window(input string tag, input logic [31:0] exp_w);
    logic [31:0] w;
    logic [15:0] a;
    sync0(tag);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (4) @(negedge clk);
      w[8*(3-d) +: 8] = char;
      a[4*(3-d) +: 4] = an;
    end
    check_eq(tag, w, exp_w);
    check_eq({tag, "_an"}, {16'd0, a}, 32'h0000_7BDE);
  endtask

  task automatic put(input logic [7:0] c);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_char = c;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  logic [31:0] hello_win [6];
  logic [71:0] s9;
  logic [31:0] w9;
  logic [7:0]  hello [5];

  initial begin
    hello_win = '{"HELL", "ELLO", "LLO ", "LO H", "O HE", " HEL"};
    hello     = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    s9        = "ABCDEFGH ";
    reset = 1'b1; wr_en = 1'b0; wr_char = 8'h00; clear = 1'b0; scroll_en = 1'b0;
    repeat (3) @(negedge clk);

    // 1: reset state, blank refresh cycle
    check_eq("rst_an",   {28'd0, an},   32'h7);
    check_eq("rst_char", {24'd0, char}, 32'h20);
    check_eq("rst_len",  {28'd0, len},  32'd0);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    reset = 1'b0;
    get_window("blank0", "    ");
    get_window("blank1", "    ");

    // 2: short text is left-aligned and never scrolls
    put(8'h41); put(8'h42);
    check_eq("ab_len", {28'd0, len}, 32'd2);
    get_window("ab_win", "AB  ");
    scroll_en = 1'b1;
    repeat (200) @(negedge clk);
    get_window("ab_hold", "AB  ");

    // 3: HELLO scrolls; ticks land between windows
    scroll_en = 1'b0;
    do_clear();
    check_eq("clr_len", {28'd0, len}, 32'd0);
    for (int i = 0; i < 5; i++) put(hello[i]);
    check_eq("hello_len", {28'd0, len}, 32'd5);
    sync0("h_start");
    repeat (14) @(negedge clk);
    scroll_en = 1'b1;
    for (int i = 0; i < 7; i++) get_window($sformatf("hello_%0d", i), hello_win[i/2]);

    // 5: freeze at offset 3, then restart a full interval
    scroll_en = 1'b0;
    for (int i = 0; i < 6; i++) get_window($sformatf("frz_%0d", i), hello_win[3]);
    repeat (2) @(negedge clk);
    scroll_en = 1'b1;
    get_window("re_0", hello_win[3]);
    get_window("re_1", hello_win[3]);
    get_window("re_2", hello_win[4]);
    get_window("re_3", hello_win[4]);
    get_window("re_4", hello_win[5]);
    get_window("re_5", hello_win[5]);
    get_window("re_wrap", hello_win[0]);

    // 6: async reset between edges
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_an",   {28'd0, an},   32'h7);
    check_eq("ar_char", {24'd0, char}, 32'h20);
    check_eq("ar_len",  {28'd0, len},  32'd0);
    @(negedge clk);
    scroll_en = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("ar_d0", {28'd0, an}, 32'h7);
    @(negedge clk);
    check_eq("ar_d1",   {28'd0, an},   32'hB);
    check_eq("ar_ch1",  {24'd0, char}, 32'h20);

    // 4: fill, overflow write dropped, clear beats write
    for (int i = 0; i < 8; i++) put(8'h41 + 8'(i));
    check_eq("f_len",  {28'd0, len},  32'd8);
    check_eq("f_full", {31'd0, full}, 32'd1);
    put(8'h5A);
    check_eq("ovf_len",  {28'd0, len},  32'd8);
    check_eq("ovf_full", {31'd0, full}, 32'd1);
    sync0("f_start");
    repeat (14) @(negedge clk);
    scroll_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      for (int d = 0; d < 4; d++) w9[8*(3-d) +: 8] = s9[8*(8 - ((i/2 + d) % 9)) +: 8];
      get_window($sformatf("full_%0d", i), w9);
    end
    scroll_en = 1'b0;
    @(negedge clk);
    clear = 1'b1; wr_en = 1'b1; wr_char = 8'h51;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    check_eq("cw_len",  {28'd0, len},  32'd0);
    check_eq("cw_full", {31'd0, full}, 32'd0);
    get_window("cw_win", "    ");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
